// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher datapath: default frame and key
// sizes, the receive state encoding and the byte type.
package xor_cipher_pkg;

    localparam int KEY_SIZE_DEF = 32;
    localparam int MSG_SIZE_DEF = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CLOSE = 2'd2
    } state_e;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO. The head entry is read combinationally from
// storage so a byte is visible the cycle after it is written. A push while
// full is only accepted when a pop frees the slot on the same edge.
module byte_fifo
    import xor_cipher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  byte_t push_data,
    input  logic  pop,
    output byte_t head_data,
    output logic  full,
    output logic  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    byte_t          mem_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           pop_ok;
    logic           push_ok;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem_reg[rd_ptr_reg];

    // Storage write; entries are cleared on reset so the head reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_stream_decrypt.sv
// Receive side of the XOR cipher link: samples the framed serial ciphertext,
// strips the repeating key bit by bit, assembles plaintext bytes MSB-first
// and queues them for a valid/ready consumer. Frame errors (early/missing
// end, restart, FIFO overflow) are sticky until the next accepted start.
// Optional feature: define XOR_DEC_CHECKSUM_EN to add oChecksum, the XOR of
// every plaintext byte assembled in the current frame.
module xor_stream_decrypt
    import xor_cipher_pkg::*;
#(
    parameter int KEY_SIZE   = KEY_SIZE_DEF,
    parameter int MSG_SIZE   = MSG_SIZE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iEn,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic                iKey_load,
    input  logic                iSerial_in,
    input  logic                iSerial_start,
    input  logic                iSerial_end,
    output logic [7:0]          oByte,
    output logic                oByte_valid,
    input  logic                iByte_ready,
    output logic                oFrame_done,
    output logic                oFrame_err,
`ifdef XOR_DEC_CHECKSUM_EN
    output logic [7:0]          oChecksum,
`endif
    output logic                oBusy
);

    localparam int BW = (MSG_SIZE > 1) ? $clog2(MSG_SIZE) : 1;
    localparam int KW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;

    state_e                state_reg,   state_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [KW-1:0]         key_idx_reg, key_idx_next;
    logic [KEY_SIZE-1:0]   key_reg,     key_next;
    logic [6:0]            asm_reg,     asm_next;
    logic [2:0]            asm_cnt_reg, asm_cnt_next;
    logic                  err_reg,     err_next;
`ifdef XOR_DEC_CHECKSUM_EN
    byte_t                 cs_reg,      cs_next;
`endif

    logic                  take_bit;
    logic                  restart;
    logic [BW-1:0]         cur_bit;
    logic [KW-1:0]         cur_kidx;
    logic [6:0]            asm_base;
    logic [2:0]            cnt_base;
    logic                  plain_bit;
    byte_t                 byte_new;
    logic                  push;
    logic                  pop_ok;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign oByte_valid = !fifo_empty;
    assign pop_ok      = oByte_valid && iByte_ready;
    assign oFrame_done = (state_reg == CLOSE);
    assign oBusy       = (state_reg == RECV);
    assign oFrame_err  = err_reg;
`ifdef XOR_DEC_CHECKSUM_EN
    assign oChecksum   = cs_reg;
`endif

    // Next-state logic: frame tracking, key stripping and byte assembly.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        key_idx_next = key_idx_reg;
        key_next     = key_reg;
        asm_next     = asm_reg;
        asm_cnt_next = asm_cnt_reg;
        err_next     = err_reg;
`ifdef XOR_DEC_CHECKSUM_EN
        cs_next      = cs_reg;
`endif
        take_bit     = 1'b0;
        restart      = 1'b0;
        push         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (iKey_load) begin
                    key_next = iKey;
                end
                if (iEn && iSerial_start) begin
                    take_bit = 1'b1;
                    restart  = 1'b1;
                    err_next = 1'b0;
                end
            end
            RECV: begin
                if (iEn) begin
                    take_bit = 1'b1;
                    if (iSerial_start) begin
                        restart  = 1'b1;
                        err_next = 1'b1;
                    end
                end
            end
            CLOSE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A (re)start treats the current bit as frame bit MSG_SIZE-1 with a
        // fresh key index and an empty assembler.
        cur_bit   = restart ? BW'(MSG_SIZE-1) : bit_cnt_reg;
        cur_kidx  = restart ? KW'(KEY_SIZE-1) : key_idx_reg;
        asm_base  = restart ? 7'd0 : asm_reg;
        cnt_base  = restart ? 3'd0 : asm_cnt_reg;
        plain_bit = iSerial_in ^ key_reg[cur_kidx];
        byte_new  = {asm_base, plain_bit};

        if (take_bit) begin
`ifdef XOR_DEC_CHECKSUM_EN
            if (restart) begin
                cs_next = '0;
            end
`endif
            asm_next     = byte_new[6:0];
            asm_cnt_next = cnt_base + 1'b1;
            if (cnt_base == 3'd7) begin
                push = 1'b1;
`ifdef XOR_DEC_CHECKSUM_EN
                cs_next = (restart ? 8'd0 : cs_reg) ^ byte_new;
`endif
            end
            key_idx_next = (cur_kidx == '0) ? KW'(KEY_SIZE-1) : cur_kidx - 1'b1;

            if (iSerial_end) begin
                state_next = CLOSE;
                if (cur_bit != '0) begin
                    // Early end: whatever sits in the assembler is dropped.
                    err_next     = 1'b1;
                    asm_next     = '0;
                    asm_cnt_next = '0;
                end
            end else if (cur_bit == '0) begin
                state_next = CLOSE;
                err_next   = 1'b1;
            end else begin
                state_next   = RECV;
                bit_cnt_next = cur_bit - 1'b1;
            end
        end

        // The serial link cannot be stalled, so a byte with no room is lost.
        if (push && fifo_full && !pop_ok) begin
            err_next = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            key_idx_reg <= '0;
            key_reg     <= '0;
            asm_reg     <= '0;
            asm_cnt_reg <= '0;
            err_reg     <= 1'b0;
`ifdef XOR_DEC_CHECKSUM_EN
            cs_reg      <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            key_idx_reg <= key_idx_next;
            key_reg     <= key_next;
            asm_reg     <= asm_next;
            asm_cnt_reg <= asm_cnt_next;
            err_reg     <= err_next;
`ifdef XOR_DEC_CHECKSUM_EN
            cs_reg      <= cs_next;
`endif
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (byte_new),
        .pop       (iByte_ready),
        .head_data (oByte),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Self-checking bench for xor_stream_decrypt: a queue-based reference model
// is compared against the DUT every cycle, plus literal expectations.
module tb_xor_stream_decrypt;

    localparam int KS = 32;
    localparam int MS = 512;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iEn, iKey_load, iSerial_in, iSerial_start, iSerial_end, iByte_ready;
    logic [KS-1:0] iKey;
    logic [7:0]    oByte;
    logic          oByte_valid, oFrame_done, oFrame_err, oBusy;
`ifdef XOR_DEC_CHECKSUM_EN
    logic [7:0]    oChecksum;
`endif

    xor_stream_decrypt #(.KEY_SIZE(KS), .MSG_SIZE(MS), .FIFO_DEPTH(FD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iEn           (iEn),
        .iKey          (iKey),
        .iKey_load     (iKey_load),
        .iSerial_in    (iSerial_in),
        .iSerial_start (iSerial_start),
        .iSerial_end   (iSerial_end),
        .oByte         (oByte),
        .oByte_valid   (oByte_valid),
        .iByte_ready   (iByte_ready),
        .oFrame_done   (oFrame_done),
        .oFrame_err    (oFrame_err),
`ifdef XOR_DEC_CHECKSUM_EN
        .oChecksum     (oChecksum),
`endif
        .oBusy         (oBusy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [KS-1:0] m_key;
    logic          m_active, m_close, m_err;
    int            m_pos, m_acc;
    logic [7:0]    m_q[$];

    // Observations
    logic [7:0]    got_q[$];
    int            done_cnt;
    int            rdy_mode;   // 0: always ready, 1: never, 2: random

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_active = 0; m_close = 0; m_err = 0; m_pos = 0; m_acc = 0;
        m_q.delete();
    endtask

    task automatic clear_obs();
        got_q.delete();
        done_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic en, input logic st, input logic nd, input logic din,
                        input logic ld, input logic [KS-1:0] k);
        logic rdy, was_close, do_proc, have_push, b;
        logic [7:0] push_val;
        int idx;
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        iEn = en; iSerial_start = st; iSerial_end = nd; iSerial_in = din;
        iKey_load = ld; iKey = k; iByte_ready = rdy;
        if (oByte_valid && rdy) got_q.push_back(oByte);

        was_close = m_close; m_close = 0; do_proc = 0; have_push = 0; push_val = '0;
        if (!was_close) begin
            if (!m_active) begin
                if (ld) m_key = k;
                if (en && st) begin
                    m_err = 0; m_active = 1; m_pos = 0; m_acc = 0; do_proc = 1;
                end
            end else if (en) begin
                if (st) begin
                    m_err = 1; m_pos = 0; m_acc = 0;
                end
                do_proc = 1;
            end
        end
        if (do_proc) begin
            b = din ^ m_key[KS - 1 - (m_pos % KS)];
            m_acc = ((m_acc << 1) | int'(b)) & 255;
            m_pos++;
            if (m_pos % 8 == 0) begin
                have_push = 1; push_val = 8'(m_acc); m_acc = 0;
            end
            idx = MS - m_pos;
            if (nd || idx == 0) begin
                if (idx != 0 || !nd) m_err = 1;
                m_active = 0; m_close = 1;
            end
        end
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (have_push) begin
            if (m_q.size() >= FD) m_err = 1;
            else m_q.push_back(push_val);
        end

        @(posedge clk); #1;
        chk("valid", 32'(oByte_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("byte", 32'(oByte), 32'(m_q[0]));
        chk("err", 32'(oFrame_err), 32'(m_err));
        chk("done", 32'(oFrame_done), 32'(m_close));
        chk("busy", 32'(oBusy), 32'(m_active));
        if (oFrame_done) done_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
    endtask

    task automatic load_key(input logic [KS-1:0] k);
        step(0, 0, 0, 0, 1, k);
    endtask

    // Send bits MS-1 down to MS-nbits; end strobe at bit end_at (-1: none).
    task automatic send_frame(input logic [MS-1:0] ct, input int nbits, input int end_at,
                              input bit gaps, input bit load_mid);
        int idx;
        for (int n = 0; n < nbits; n++) begin
            idx = MS - 1 - n;
            if (gaps && $urandom_range(0, 3) == 0)
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 0, '0);
            step(1, n == 0, idx == end_at, ct[idx], load_mid && n == 300, KS'($urandom));
        end
    endtask

    function automatic logic [MS-1:0] build_ct(input logic [KS-1:0] k);
        logic [MS-1:0] ct;
        logic [7:0] kb;
        ct = '0;
        for (int bi = 0; bi < MS / 8; bi++) begin
            kb = k[KS - 1 - 8 * (bi % 4) -: 8];
            ct[MS - 1 - 8 * bi -: 8] = 8'(bi) ^ kb;
        end
        return ct;
    endfunction

    logic [MS-1:0] ct;
    logic [MS-1:0] zeros;

    initial begin
        zeros = '0;
        rdy_mode = 0;
        rst_n = 0; iEn = 0; iKey = '0; iKey_load = 0; iSerial_in = 0;
        iSerial_start = 0; iSerial_end = 0; iByte_ready = 0;
        model_reset(); clear_obs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte", 32'(oByte), 0);
        chk("rst_valid", 32'(oByte_valid), 0);
        chk("rst_done", 32'(oFrame_done), 0);
        chk("rst_err", 32'(oFrame_err), 0);
        chk("rst_busy", 32'(oBusy), 0);
        rst_n = 1;

        // Zero ciphertext decodes to the key itself.
        load_key(32'hA5A5_0F0F); clear_obs();
        send_frame(zeros, MS, 0, 0, 0); idle(8);
        chk("f1_count", got_q.size(), 64);
        chk("f1_b0", 32'(got_q[0]), 32'hA5);
        chk("f1_b1", 32'(got_q[1]), 32'hA5);
        chk("f1_b2", 32'(got_q[2]), 32'h0F);
        chk("f1_b3", 32'(got_q[3]), 32'h0F);
        chk("f1_b63", 32'(got_q[63]), 32'h0F);
        chk("f1_done_cnt", done_cnt, 1);
        chk("f1_err", 32'(oFrame_err), 0);

        // Round trip with enable gaps and an ignored mid-frame key load.
        load_key(32'hDEAD_BEEF); clear_obs();
        ct = build_ct(32'hDEAD_BEEF);
        send_frame(ct, MS, 0, 1, 1); idle(8);
        chk("rt_count", got_q.size(), 64);
        for (int i = 0; i < 64 && i < got_q.size(); i++) chk("rt_byte", 32'(got_q[i]), i);
        chk("rt_err", 32'(oFrame_err), 0);

        // Consumer stalled for the whole frame.
        load_key(32'hA5A5_0F0F); clear_obs(); rdy_mode = 1;
        send_frame(zeros, MS, 0, 0, 0); idle(4);
        chk("ovf_err", 32'(oFrame_err), 1);
        chk("ovf_valid", 32'(oByte_valid), 1);
        chk("ovf_head", 32'(oByte), 32'hA5);
        rdy_mode = 0; idle(10);
        chk("ovf_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("ovf_b2", 32'(got_q[2]), 32'h0F);
            chk("ovf_b3", 32'(got_q[3]), 32'h0F);
        end

        // Early end at bit 100.
        load_key(32'hDEAD_BEEF); clear_obs();
        send_frame(ct, MS - 100, 100, 0, 0);
        chk("early_done_next", 32'(oFrame_done), 1);
        idle(8);
        chk("early_count", got_q.size(), 51);
        if (got_q.size() == 51) chk("early_last", 32'(got_q[50]), 50);
        chk("early_err", 32'(oFrame_err), 1);
        chk("early_done_cnt", done_cnt, 1);

        // Restart at bit 200, then a full frame.
        load_key(32'hA5A5_0F0F); clear_obs();
        send_frame(zeros, MS - 201, -1, 0, 0);
        send_frame(zeros, MS, 0, 0, 0); idle(8);
        chk("rs_count", got_q.size(), 38 + 64);
        chk("rs_err", 32'(oFrame_err), 1);
        chk("rs_done_cnt", done_cnt, 1);

        // Missing end strobe.
        clear_obs();
        send_frame(zeros, MS, -1, 0, 0); idle(8);
        chk("miss_count", got_q.size(), 64);
        chk("miss_err", 32'(oFrame_err), 1);

        // Start during CLOSE is ignored; the next cycle's start is taken.
        clear_obs();
        send_frame(zeros, MS, 0, 0, 0);
        step(1, 1, 0, 0, 0, '0);
        send_frame(zeros, MS, 0, 0, 0); idle(8);
        chk("b2b_count", got_q.size(), 128);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_err", 32'(oFrame_err), 0);

        // Randomized frames, model-checked every cycle.
        for (int f = 0; f < 6; f++) begin
            load_key(KS'($urandom));
            for (int w = 0; w < MS / 32; w++) ct[w * 32 +: 32] = $urandom;
            rdy_mode = 2;
            case ($urandom_range(0, 2))
                0: send_frame(ct, MS, 0, 1, 0);
                1: send_frame(ct, MS, -1, 1, 0);
                default: begin
                    int e;
                    e = $urandom_range(1, MS - 2);
                    send_frame(ct, MS - e, e, 1, 0);
                end
            endcase
            idle($urandom_range(0, 3));
        end
        rdy_mode = 0; idle(8);

        // Asynchronous reset mid-frame.
        load_key(32'hDEAD_BEEF);
        send_frame(ct, 100, -1, 0, 0);
        rst_n = 0; #2;
        chk("arst_busy", 32'(oBusy), 0);
        chk("arst_valid", 32'(oByte_valid), 0);
        chk("arst_byte", 32'(oByte), 0);
        chk("arst_err", 32'(oFrame_err), 0);
        chk("arst_done", 32'(oFrame_done), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1; clear_obs();
        for (int w = 0; w < MS / 32; w++) ct[w * 32 +: 32] = $urandom;
        send_frame(ct, MS, 0, 0, 0); idle(8);
        chk("k0_count", got_q.size(), 64);
        if (got_q.size() == 64) begin
            chk("k0_b0", 32'(got_q[0]), 32'(ct[MS - 1 -: 8]));
            chk("k0_b63", 32'(got_q[63]), 32'(ct[7:0]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
